// File: rtl/dwrr_cfg.sv
// Double-buffered DWRR quantum table: host writes a shadow bank, which is copied atomically to
// the active bank on a round boundary or on timeout. Optional clamp: DWRR_CFG_CLAMP_EN.
module dwrr_cfg #(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int PSIZE    = 8,
    parameter int DEF_Q    = 16,
    parameter int TMO      = 255,
    parameter int AWID     = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AWID-1:0]          wr_addr,
    input  logic [QWID-1:0]          wr_data,
    input  logic                     commit_req,
    input  logic                     round_end,
    output logic                     commit_ack,
    output logic                     pending,
    output logic                     timeout,
    output logic                     err,
    output logic [NUM_REQS*QWID-1:0] quantums_out
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDirty  = 2'd1;
    localparam logic [1:0] StArmed  = 2'd2;
    localparam logic [1:0] StCommit = 2'd3;

    localparam logic [31:0]     NumReqsU = NUM_REQS;
    localparam logic [7:0]      TmoLast  = 8'(TMO - 1);
    localparam logic [QWID-1:0] DefQ     = QWID'(DEF_Q);

    logic [1:0]      state_q, state_d;
    logic [QWID-1:0] shadow_q [NUM_REQS];
    logic [QWID-1:0] active_q [NUM_REQS];
    logic [7:0]      cnt_q;
    logic            err_q, timeout_q;

    logic            wr_fire, addr_ok, tmo_hit, load_active, forced;
    logic [QWID-1:0] wdata;

    always_comb begin
        wr_fire = wr_valid & wr_ready;
        addr_ok = 32'(wr_addr) < NumReqsU;
`ifdef DWRR_CFG_CLAMP_EN
        wdata = (wr_data < QWID'(PSIZE)) ? QWID'(PSIZE) : wr_data;
`else
        wdata = wr_data;
`endif
        // Counter sits at 0 on the first ARMED cycle, so TMO ARMED cycles elapse before the copy.
        tmo_hit     = cnt_q >= TmoLast;
        load_active = (state_q == StArmed) && (round_end || tmo_hit);
        forced      = (state_q == StArmed) && !round_end && tmo_hit;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (wr_fire && addr_ok) state_d = StDirty;
            StDirty:  if (commit_req) state_d = StArmed;
            StArmed:  if (load_active) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_REQS; i++) begin
                shadow_q[i] <= DefQ;
                active_q[i] <= DefQ;
            end
        end else begin
            state_q <= state_d;
            err_q   <= wr_fire && !addr_ok;
            if (wr_fire && addr_ok) begin
                for (int i = 0; i < NUM_REQS; i++) begin
                    if (32'(wr_addr) == 32'(i)) shadow_q[i] <= wdata;
                end
            end
            // Shadow is frozen outside IDLE/DIRTY, so this copy is a single coherent snapshot.
            if (load_active) begin
                for (int i = 0; i < NUM_REQS; i++) active_q[i] <= shadow_q[i];
            end
            if (forced) timeout_q <= 1'b1;
            if (state_q == StDirty && commit_req) begin
                cnt_q <= 8'd0;
            end else if (state_q == StArmed && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) quantums_out[i*QWID +: QWID] = active_q[i];
    end

    assign wr_ready   = (state_q == StIdle) || (state_q == StDirty);
    assign pending    = state_q != StIdle;
    assign commit_ack = state_q == StCommit;
    assign err        = err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_dwrr_cfg.sv
// Directed bench for dwrr_cfg: expected active banks are queued per commit and checked on
// every commit_ack by an independent monitor.
module tb_dwrr_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit_req;
    logic        round_end;
    logic        commit_ack;
    logic        pending;
    logic        timeout;
    logic        err;
    logic [31:0] quantums_out;

    int errors = 0;
    int checks = 0;
    int ack_count = 0;
    logic [32:0] sb_q [$];  // {timeout, quantums_out}

    always #5 clk = ~clk;

    dwrr_cfg #(
        .NUM_REQS (4),
        .QWID     (8),
        .PSIZE    (8),
        .DEF_Q    (16),
        .TMO      (10),
        .AWID     (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit_req   (commit_req),
        .round_end    (round_end),
        .commit_ack   (commit_ack),
        .pending      (pending),
        .timeout      (timeout),
        .err          (err),
        .quantums_out (quantums_out)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && commit_ack) begin
            ack_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_commit_ack", {timeout, quantums_out}, 33'h0);
            end else begin
                check("commit_bank", {timeout, quantums_out}, sb_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // commit_req for one cycle, then round_end after gap further ARMED cycles.
    task automatic commit_round(input int gap, input logic [32:0] exp);
        sb_q.push_back(exp);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        check("armed_wr_ready", {32'h0, wr_ready}, 33'h0);
        check("armed_pending", {32'h0, pending}, 33'h1);
        repeat (gap) @(negedge clk);
        round_end = 1'b1;
        @(negedge clk);
        round_end = 1'b0;
        check("ack_after_round_end", {32'h0, commit_ack}, 33'h1);
        @(negedge clk);
        check("idle_after_commit", {31'h0, commit_ack, pending}, 33'h0);
    endtask

    initial begin
        int n;
        logic [31:0] ack_snap;
        logic [7:0]  slot0_clamp;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
        commit_req = 1'b0; round_end = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_quantums", {1'b0, quantums_out}, {1'b0, 32'h10101010});
        check("reset_flags", {28'h0, wr_ready, pending, commit_ack, err, timeout},
              {28'h0, 5'b10000});

        // round_end in IDLE is ignored
        round_end = 1'b1;
        @(negedge clk);
        round_end = 1'b0;
        @(negedge clk);
        check("round_end_idle", {31'h0, commit_ack, pending}, 33'h0);

        wr(3'd2, 8'd32);
        check("dirty_pending", {31'h0, wr_ready, pending}, 33'h3);
        check("dirty_active_old", {1'b0, quantums_out}, {1'b0, 32'h10101010});
        commit_round(2, {1'b0, 32'h10201010});

        // Latency: round_end already high, new bank visible two cycles after commit_req
        wr(3'd1, 8'd40);
        sb_q.push_back({1'b0, 32'h10202810});
        commit_req = 1'b1; round_end = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        check("latency_cycle1_old", {1'b0, quantums_out}, {1'b0, 32'h10201010});
        @(negedge clk);
        round_end = 1'b0;
        check("latency_cycle2_new", {1'b0, quantums_out}, {1'b0, 32'h10202810});
        @(negedge clk);

        // Write and commit in the same DIRTY cycle: write is included
        wr(3'd3, 8'h30);
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 8'h40;
        sb_q.push_back({1'b0, 32'h30202840});
        commit_req = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; commit_req = 1'b0;
        round_end = 1'b1;
        @(negedge clk);
        round_end = 1'b0;
        check("same_cycle_ack", {32'h0, commit_ack}, 33'h1);
        @(negedge clk);

        // Timeout-forced commit
        wr(3'd0, 8'h50);
        sb_q.push_back({1'b1, 32'h30202850});
        commit_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) commit_req = 1'b0;
        end while (!commit_ack && n < 40);
        check("timeout_latency", 33'(n), 33'd11);
        repeat (4) @(negedge clk);
        check("timeout_sticky", {31'h0, timeout, pending}, 33'h2);

        // Out-of-range write in DIRTY: err pulse, slot 1 (alias of 5) untouched
        wr(3'd3, 8'h60);
        wr(3'd5, 8'h77);
        check("err_pulse", {31'h0, err, pending}, 33'h3);
        @(negedge clk);
        check("err_one_cycle", {32'h0, err}, 33'h0);
        commit_round(0, {1'b1, 32'h60202850});

        // Out-of-range write in IDLE: no state change
        wr(3'd5, 8'h77);
        check("err_idle", {31'h0, err, pending}, 33'h2);

`ifdef DWRR_CFG_CLAMP_EN
        slot0_clamp = 8'd8;
`else
        slot0_clamp = 8'd3;
`endif
        wr(3'd0, 8'd3);
        commit_round(1, {1'b1, 24'h602028, slot0_clamp});

        // Reset in ARMED: no commit, back to defaults
        ack_snap = 32'(ack_count);
        wr(3'd2, 8'h99);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_armed_quantums", {1'b0, quantums_out}, {1'b0, 32'h10101010});
        check("rst_armed_flags", {28'h0, wr_ready, pending, commit_ack, err, timeout},
              {28'h0, 5'b10000});
        round_end = 1'b1;
        commit_req = 1'b1;
        repeat (3) @(negedge clk);
        round_end = 1'b0; commit_req = 1'b0;
        check("rst_armed_no_ack", {1'b0, 32'(ack_count)}, {1'b0, ack_snap});
        check("commit_req_idle_ignored", {32'h0, pending}, 33'h0);

        wr(3'd1, 8'h21);
        commit_round(0, {1'b0, 32'h10102110});

        check("scoreboard_drained", 33'(sb_q.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dwrr_cfg.md
DWRR_CFG -- requirements
Module: dwrr_cfg

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  NUM_REQS  4    number of requestors/quantum slots
  QWID      8    quantum width, bits
  PSIZE     8    packet size; minimum legal quantum
  DEF_Q     16   reset quantum of every slot
  TMO       255  ARMED-state timeout, cycles (1..255)
  AWID      $clog2(NUM_REQS)  write-address width
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk           in   1              single clock; all state updates on its rising edge
  rst           in   1              synchronous, active-high reset
  wr_valid      in   1              shadow-write request
  wr_ready      out  1              shadow write accepted when wr_valid & wr_ready
  wr_addr       in   AWID           slot index
  wr_data       in   QWID           quantum value
  commit_req    in   1              request transfer of shadow bank to active bank
  round_end     in   1              scheduler round boundary: round-robin count wraps NUM_REQS-1 -> 0
  commit_ack    out  1              one-cycle pulse on the cycle the active bank updates
  pending       out  1              shadow differs from active or commit is armed
  timeout       out  1              sticky; set when a commit was forced by timeout
  err           out  1              one-cycle pulse on an accepted write with wr_addr >= NUM_REQS
  quantums_out  out  NUM_REQS*QWID  active bank; slot i at bits [(i+1)*QWID-1 : i*QWID]

Function
REQ-003 The block SHALL hold two banks of NUM_REQS x QWID registers: shadow (written by host) and active (driven on quantums_out).
REQ-004 The FSM SHALL have states IDLE, DIRTY, ARMED and COMMIT.
REQ-005 wr_ready SHALL be 1 in IDLE and DIRTY and 0 in ARMED and COMMIT.
REQ-006 An accepted write SHALL update shadow[wr_addr] the next cycle and move IDLE->DIRTY.
REQ-007 An accepted write with wr_addr >= NUM_REQS SHALL be discarded, SHALL pulse err the next cycle, and SHALL cause no state change.
REQ-008 commit_req in DIRTY SHALL move to ARMED, clear the timeout counter, and SHALL be ignored in every other state.
REQ-009 If commit_req and an accepted write occur in the same DIRTY cycle, the block SHALL apply the write first and then arm, so the write is included in the commit.
REQ-010 ARMED SHALL move to COMMIT on the first cycle with round_end=1, or when the 8-bit timeout counter reaches TMO; the latter SHALL set timeout.
REQ-011 In COMMIT the active bank SHALL load the entire shadow bank in one cycle, commit_ack SHALL pulse, and the state SHALL return to IDLE the next cycle.
REQ-012 The commit SHALL be atomic: quantums_out SHALL never show a mix of old and new banks.
REQ-013 Latency: with round_end=1 already in the arming cycle+1, quantums_out SHALL change 2 cycles after commit_req.
REQ-014 pending SHALL be 1 in DIRTY, ARMED and COMMIT, and 0 in IDLE.
REQ-015 The timeout counter SHALL saturate and never wrap; round_end outside ARMED SHALL be ignored.

Reset
REQ-016 On rst=1 at a clock edge: both banks = DEF_Q, state = IDLE, counter = 0, commit_ack = err = timeout = pending = 0, wr_ready = 1.
REQ-017 rst asserted in any state, including mid-ARMED or COMMIT, SHALL take priority; no partial commit SHALL occur.

Configuration
REQ-018 When macro DWRR_CFG_CLAMP_EN is defined, accepted writes with wr_data < PSIZE SHALL store PSIZE; when it is undefined, wr_data SHALL be stored unmodified.

Verification
REQ-019 Reset -> quantums_out = {4{8'd16}}, wr_ready = 1, pending = 0.
REQ-020 Write slot 2 = 32, commit_req, round_end 3 cycles later -> commit_ack one cycle after round_end, slot 2 = 32, other slots = 16, timeout = 0.
REQ-021 TMO = 10, armed with no round_end -> COMMIT after 10 ARMED cycles, timeout = 1 and stays 1 until rst.
REQ-022 wr_addr = 5 with NUM_REQS = 4 -> err pulse, shadow unchanged, pending unchanged.
REQ-023 Write 8'd3 to slot 0 -> stored as 8 with DWRR_CFG_CLAMP_EN defined, stored as 3 without it.
REQ-024 rst asserted during ARMED -> active bank = DEF_Q, no commit_ack, state = IDLE.
